johnson_decoder: RTL and testbench
==================================

# johnson_decoder

- Receive-side companion to the team's `johnson_counter`: samples a WIDTH-bit Johnson (twisted-ring) code each clock.
- Decodes each sample to a binary phase index and checks code legality and step-by-step succession.
- Tracks lock to the counter's sequence and counts errors.
- Sits downstream of any Johnson counter used as a phase generator, as a decoder and sequence monitor.

## Interface
Parameters:
- WIDTH, 4, Johnson code width; legal range 2..16; ring length is 2*WIDTH.
- LOCK_LEN, 3, consecutive successor steps required to declare lock; legal range 1..15.

IW = $clog2(2*WIDTH) (3 for defaults).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- i  input  1  reset; synchronous, active-high.
- q_in  input  WIDTH  Johnson code sampled every clk.
- idx  output  IW  decoded phase index 0..2*WIDTH-1; holds last legal value when the input is illegal.
- legal  output  1  1 = the sample behind the current outputs was a legal Johnson code.
- locked  output  1  sequence lock status.
- err  output  1  one-cycle pulse on illegal code, or on a sequence break while locked.
- wrap  output  1  one-cycle pulse when locked and idx steps from 2*WIDTH-1 to 0.
- err_cnt  output  8  saturating error count.

## Operation
- **Code convention:** the sequence matches the team counter, `q <= {q[W-2:0], ~q[W-1]}`. For WIDTH=4 the ring is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 (idx 0..7).
- **Legality:**
  - If q[W-1]=0, the code must be contiguous ones from the LSB (0…01…1), including all-zero.
  - If q[W-1]=1, the code must be contiguous ones from the MSB (1…10…0), including all-one.
  - Every other code is illegal (2^W - 2W codes).
- **Decode:**
  - q[W-1]=0: idx = popcount(q).
  - q[W-1]=1: idx = 2W - popcount(q).
  - Arithmetic is IW-bit.
- **Classification** of each legal sample against the previous index `prev`, valid only when `prev_ok`=1:
  - successor: idx == (prev+1) mod 2W; 2W-1 to 0 wraps.
  - stall: idx == prev. Neither an error nor progress.
  - skip: any other legal idx.
- **FSM:** two states, UNLOCKED (reset state) and LOCKED. A 4-bit run counter `run` drives lock.
- **UNLOCKED:**
  - illegal: err=1, err_cnt++, run=0, prev_ok=0.
  - legal with prev_ok=0: prev_ok=1, run unchanged.
  - successor: run++. When run reaches LOCK_LEN, go to LOCKED on the same edge; locked=1 with that idx.
  - skip: run=0, no err.
  - stall: no change.
- **LOCKED:**
  - successor or stall: stay LOCKED. wrap=1 on the 2W-1 to 0 successor.
  - illegal: err=1, err_cnt++, go to UNLOCKED, run=0, prev_ok=0.
  - skip: err=1, err_cnt++, go to UNLOCKED, run=0, prev_ok stays 1 (the new idx becomes prev).
- **Index hold:** idx and prev update only on legal samples.
- **err_cnt:** saturates at 255 and never wraps. Only reset clears it.

## Timing
- **Stage 1:** q_in is registered into q_r at every edge.
- **Stage 2:** decode and classify q_r; outputs register at the next edge.
- **Latency:** q_in present before edge k appears on the outputs after edge k+1, i.e. 2 cycles. err and wrap align with the same sample.
- **Reset** (i=1 at an edge): all of the following go to 0 on that edge, with no dependence on q_in:
  - q_r, idx, legal, locked, err, wrap, err_cnt, run, prev_ok.
  - State returns to UNLOCKED.
- **Reset duration:** reset mid-lock drops locked on the first reset edge. Samples taken while i=1 are discarded.
- **err and wrap** are pulses, high for exactly one cycle per event. Back-to-back events give consecutive high cycles.
- **Simultaneous events:** an illegal code while err_cnt=255 still pulses err; the count stays at 255.

## Test plan
1. **Reset:** i=1 for 2 edges with q_in=0101 → idx=0, legal=0, locked=0, err=0, wrap=0, err_cnt=0.
2. **Ring and lock:** release reset, drive 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 one per clk.
   - idx reads 0..7, 0, each 2 cycles after its input; legal=1 throughout.
   - locked rises with idx=3.
   - wrap pulses once with idx=0 (second pass); err stays 0.
3. **Illegal code:** while locked, inject 0101 → legal=0, idx holds last value, err pulses 1 cycle, err_cnt=1, locked=0.
   - Continue from 0011 → relock after 3 further successor samples.
4. **Skip:** while locked, 0001 then 0111 → err pulse, err_cnt increments, locked=0, idx=3.
5. **Stall:** while locked, drive 0011 three times → locked stays 1, err=0, wrap=0, idx=2.
6. **Saturation and reset mid-lock:** 300 illegal samples → err_cnt stops at 255 and err keeps pulsing. Then lock and assert i=1 for one edge → all outputs 0 on that edge.

Source files
------------

// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code decoder and sequence monitor: decodes each sample to a
// phase index, flags illegal codes and sequence breaks, tracks lock, counts errors.
module johnson_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 3,
    localparam int IW      = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             i,
    input  logic [WIDTH-1:0] q_in,
    output logic [IW-1:0]    idx,
    output logic             legal,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [7:0]       err_cnt
);

    localparam logic [IW:0]   RING_LEN = (IW+1)'(2*WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(2*WIDTH - 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic             q_v;
    logic [3:0]       run;
    logic             prev_ok;

    logic [IW:0]      pop;
    logic             code_ok;
    logic [IW-1:0]    idx_c;
    logic [IW-1:0]    succ_idx;
    logic             is_succ;
    logic             is_stall;
    logic [7:0]       cnt_inc;

    // MSB=0 codes fill ones upward from bit 0; MSB=1 codes hold ones down from the MSB.
    always_comb begin
        pop     = '0;
        code_ok = 1'b1;
        for (int j = 0; j < WIDTH; j++) begin
            pop = pop + {{IW{1'b0}}, q_r[j]};
        end
        for (int j = 0; j < WIDTH - 1; j++) begin
            if (!q_r[WIDTH-1]) begin
                if (q_r[j+1] && !q_r[j]) code_ok = 1'b0;
            end else begin
                if (q_r[j] && !q_r[j+1]) code_ok = 1'b0;
            end
        end
        idx_c    = q_r[WIDTH-1] ? IW'(RING_LEN - pop) : IW'(pop);
        succ_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        is_succ  = prev_ok && (idx_c == succ_idx);
        is_stall = prev_ok && (idx_c == idx);
        cnt_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (i) begin
            state   <= UNLOCKED;
            q_r     <= '0;
            q_v     <= 1'b0;
            idx     <= '0;
            legal   <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
            wrap    <= 1'b0;
            err_cnt <= 8'd0;
            run     <= 4'd0;
            prev_ok <= 1'b0;
        end else begin
            q_r  <= q_in;
            q_v  <= 1'b1;
            err  <= 1'b0;
            wrap <= 1'b0;
            // q_v masks the reset value of q_r so only real samples are judged.
            if (q_v) begin
                legal <= code_ok;
                if (!code_ok) begin
                    err     <= 1'b1;
                    err_cnt <= cnt_inc;
                    run     <= 4'd0;
                    prev_ok <= 1'b0;
                    state   <= UNLOCKED;
                    locked  <= 1'b0;
                end else begin
                    idx     <= idx_c;
                    prev_ok <= 1'b1;
                    case (state)
                        UNLOCKED: begin
                            if (is_succ) begin
                                run <= run + 4'd1;
                                if (run + 4'd1 == 4'(LOCK_LEN)) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else if (prev_ok && !is_stall) begin
                                run <= 4'd0;
                            end
                        end
                        LOCKED: begin
                            if (is_succ) begin
                                if (idx == LAST_IDX) wrap <= 1'b1;
                            end else if (!is_stall) begin
                                err     <= 1'b1;
                                err_cnt <= cnt_inc;
                                run     <= 4'd0;
                                state   <= UNLOCKED;
                                locked  <= 1'b0;
                            end
                        end
                        default: state <= UNLOCKED;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: directed scenarios plus a random walk, checked against a
// table-driven reference model of the ring, lock and error rules.
module tb_johnson_decoder;

    localparam int W  = 4;
    localparam int LL = 3;
    localparam int RL = 2 * W;
    localparam int IW = $clog2(2 * W);

    logic          clk = 1'b0;
    logic          i = 1'b1;
    logic [W-1:0]  q_in = 4'b0101;
    logic [IW-1:0] idx;
    logic          legal, locked, err, wrap;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad = 0;

    johnson_decoder #(.WIDTH(W), .LOCK_LEN(LL)) dut (
        .clk(clk), .i(i), .q_in(q_in), .idx(idx), .legal(legal), .locked(locked),
        .err(err), .wrap(wrap), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [W-1:0] ring[RL];
    int m_idx, m_cnt, m_run;
    bit m_legal, m_locked, m_err, m_wrap, m_prevok;
    logic [W-1:0] pend;
    bit pend_v;

    function automatic void build_ring();
        logic [W-1:0] q = '0;
        for (int k = 0; k < RL; k++) begin
            ring[k] = q;
            q = {q[W-2:0], ~q[W-1]};
        end
    endfunction

    function automatic int find_code(logic [W-1:0] c);
        for (int k = 0; k < RL; k++) if (ring[k] == c) return k;
        return -1;
    endfunction

    function automatic void model_reset();
        m_idx = 0; m_cnt = 0; m_run = 0;
        m_legal = 0; m_locked = 0; m_err = 0; m_wrap = 0; m_prevok = 0;
        pend_v = 0;
    endfunction

    function automatic void model_step(logic [W-1:0] code);
        int k = find_code(code);
        bit succ, stall;
        m_err = 0;
        m_wrap = 0;
        m_legal = (k >= 0);
        if (k < 0) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
            m_run = 0; m_prevok = 0; m_locked = 0;
            return;
        end
        succ  = m_prevok && (k == (m_idx + 1) % RL);
        stall = m_prevok && (k == m_idx);
        if (!m_locked) begin
            if (succ) begin
                m_run++;
                if (m_run == LL) m_locked = 1;
            end else if (m_prevok && !stall) begin
                m_run = 0;
            end
        end else begin
            if (succ) m_wrap = (k == 0);
            else if (!stall) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
                m_locked = 0; m_run = 0;
            end
        end
        m_idx = k;
        m_prevok = 1;
    endfunction

    function automatic logic [IW+11:0] dut_vec();
        return {idx, legal, locked, err, wrap, err_cnt};
    endfunction

    function automatic logic [IW+11:0] model_vec();
        return {IW'(m_idx), m_legal, m_locked, m_err, m_wrap, 8'(m_cnt)};
    endfunction

    // Outputs after an edge belong to the sample driven one cycle earlier.
    task automatic cycle(input logic [W-1:0] code);
        q_in = code;
        @(posedge clk);
        #1;
        if (pend_v) model_step(pend);
        pend = code;
        pend_v = 1;
    endtask

    task automatic test_reset();
        i = 1'b1;
        q_in = 4'b0101;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            total++;
            if ({idx, legal, locked, err, wrap, err_cnt} !== '0) begin
                bad++;
                $display("FAIL reset edge %0d: got=%h want=0", e, dut_vec());
            end
        end
        model_reset();
    endtask

    task automatic test_ring();
        bit seen_lock = 0;
        int wraps = 0, errs = 0;
        i = 1'b0;
        for (int s = 0; s < RL + 2; s++) begin
            cycle(ring[s % RL]);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL ring step %0d: got=%h want=%h", s, dut_vec(), model_vec());
            end
            if (locked === 1'b1 && !seen_lock) begin
                seen_lock = 1;
                total++;
                if (idx !== IW'(3)) begin
                    bad++;
                    $display("FAIL ring lock idx: got=%0d want=3", idx);
                end
            end
            wraps += int'(wrap === 1'b1);
            errs  += int'(err !== 1'b0);
        end
        total++;
        if (!seen_lock || wraps != 1 || errs != 0) begin
            bad++;
            $display("FAIL ring summary: lock=%0d wraps=%0d errs=%0d want 1 1 0", seen_lock, wraps, errs);
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] seq[6] = '{4'b0101, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1110};
        for (int s = 0; s < 6; s++) begin
            cycle(seq[s]);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL illegal step %0d: got=%h want=%h", s, dut_vec(), model_vec());
            end
            if (s == 1) begin
                total++;
                if ({legal, locked, err, idx, err_cnt} !== {1'b0, 1'b0, 1'b1, IW'(1), 8'd1}) begin
                    bad++;
                    $display("FAIL illegal event: legal=%b locked=%b err=%b idx=%0d cnt=%0d want 0 0 1 1 1",
                             legal, locked, err, idx, err_cnt);
                end
            end
            if (s == 2) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("FAIL illegal err width: got=%b want=0", err);
                end
            end
            if (s >= 4) begin
                total++;
                if (locked !== (s == 5)) begin
                    bad++;
                    $display("FAIL illegal relock step %0d: got=%b want=%b", s, locked, s == 5);
                end
            end
        end
    endtask

    task automatic test_skip();
        logic [W-1:0] seq[6] = '{4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0111, 4'b0111};
        for (int s = 0; s < 6; s++) begin
            cycle(seq[s]);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL skip step %0d: got=%h want=%h", s, dut_vec(), model_vec());
            end
        end
        total++;
        if ({err, locked, idx, err_cnt} !== {1'b1, 1'b0, IW'(3), 8'd2}) begin
            bad++;
            $display("FAIL skip event: err=%b locked=%b idx=%0d cnt=%0d want 1 0 3 2", err, locked, idx, err_cnt);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] seq[10] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000,
                                  4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
        for (int s = 0; s < 10; s++) begin
            cycle(seq[s]);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL stall step %0d: got=%h want=%h", s, dut_vec(), model_vec());
            end
            if (s >= 7) begin
                total++;
                if ({locked, err, wrap, idx} !== {1'b1, 1'b0, 1'b0, IW'(2)}) begin
                    bad++;
                    $display("FAIL stall hold %0d: locked=%b err=%b wrap=%b idx=%0d want 1 0 0 2",
                             s, locked, err, wrap, idx);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] cur, nxt;
        int k, r;
        for (int s = 0; s < 400; s++) begin
            cur = pend;
            k = find_code(cur);
            r = $urandom_range(0, 99);
            if (r < 65)      nxt = (k < 0) ? ring[$urandom_range(0, RL-1)] : ring[(k + 1) % RL];
            else if (r < 78) nxt = cur;
            else if (r < 88) nxt = ring[$urandom_range(0, RL-1)];
            else             nxt = W'($urandom_range(0, (1 << W) - 1));
            cycle(nxt);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random step %0d: got=%h want=%h", s, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] c;
        for (int s = 0; s < 300; s++) begin
            do c = W'($urandom_range(0, (1 << W) - 1)); while (find_code(c) >= 0);
            cycle(c);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL saturation step %0d: got=%h want=%h", s, dut_vec(), model_vec());
            end
            if (s > 0) begin
                total++;
                if (err !== 1'b1) begin
                    bad++;
                    $display("FAIL saturation err pulse %0d: got=%b want=1", s, err);
                end
            end
        end
        total++;
        if (err_cnt !== 8'd255) begin
            bad++;
            $display("FAIL saturation count: got=%0d want=255", err_cnt);
        end
    endtask

    task automatic test_reset_mid_lock();
        for (int s = 0; s < 5; s++) cycle(ring[s]);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL midlock pre-reset locked: got=%b want=1", locked);
        end
        i = 1'b1;
        q_in = W'($urandom_range(0, (1 << W) - 1));
        @(posedge clk);
        #1;
        total++;
        if ({idx, legal, locked, err, wrap, err_cnt} !== '0) begin
            bad++;
            $display("FAIL midlock reset edge: got=%h want=0", dut_vec());
        end
        model_reset();
        i = 1'b0;
        cycle(ring[2]);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL midlock after release: got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        build_ring();
        model_reset();
        test_reset();
        test_ring();
        test_illegal();
        test_skip();
        test_stall();
        test_random();
        test_saturation();
        test_reset_mid_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
